// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared 7-segment definitions for every display block on the board.
// Segment bytes are {a,b,c,d,e,f,g,dp}, active-high, with bit 7 = a and the
// decimal point always off.
//   SEG_0..SEG_9 : patterns for the decimal digits
//   SEG_BLANK    : all segments dark
//   bcd_to_seg() : BCD nibble -> segment byte
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hE6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Codes 10..15 cannot come out of a BCD counter. They map to blank so
  // that a corrupted nibble can never light a misleading pattern.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter_if
// Bundles the button/control inputs and the display/count outputs of
// bcd_scan_counter.
//   s1       : raw bouncing step button, active-high
//   dir      : step direction level (0 = up, 1 = down)
//   clr      : synchronous clear, active-high
//   led      : segment byte {a,b,c,d,e,f,g,dp}
//   digit_en : one-hot digit select, bit 0 = least significant digit
//   count    : packed BCD value, nibble 0 = least significant digit
//   wrap     : one-cycle pulse when a step crosses all-9s <-> all-0s
// The master modport is the counter itself; the slave modport is the board
// side (buttons in, display connector out).
// ---------------------------------------------------------------------------
interface bcd_scan_counter_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    s1;
  logic                    dir;
  logic                    clr;
  logic [7:0]              led;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    wrap;

  modport master (
    input  s1, dir, clr,
    output led, digit_en, count, wrap
  );

  modport slave (
    output s1, dir, clr,
    input  led, digit_en, count, wrap
  );

endinterface

// File: rtl/bcd_scan_counter_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Conditions one raw mechanical button into a clean level and a press pulse.
//   clock : system clock, rising edge
//   rst   : asynchronous active-low reset
//   din   : raw asynchronous button input
//   dout  : debounced level
//   rise  : one-cycle pulse after dout goes 0 -> 1
// A new level is accepted only after the synchronised input has differed
// from dout for DEBOUNCE_CYCLES consecutive cycles.
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Any cycle where the input agrees with the accepted level restarts the
  // count. The level flips on the cycle that completes the stable run.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else if (sync2 == dout) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_cnt <= '0;
      dout       <= sync2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Registered rising-edge detector. Releasing the button is ignored, and
  // holding it produces only this single pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= dout;
      rise    <= dout & ~level_d;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter
// Counts debounced button presses in an N-digit BCD counter and scans the
// value onto one shared 7-segment bus.
//   clock : system clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : bcd_scan_counter_if.master (s1, dir, clr in; led, digit_en,
//           count, wrap out)
// Parameters: NUM_DIGITS (1..8), DEBOUNCE_CYCLES (>= 2), SCAN_DIV (>= 2),
// LEAD_BLANK (1 = blank leading zeros, digit 0 is always shown).
// ---------------------------------------------------------------------------
module bcd_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_DIV        = 10000,
  parameter bit LEAD_BLANK      = 1'b1
) (
  input  logic            clock,
  input  logic            rst,
  bcd_scan_counter_if.master bus
);

  localparam int CNT_W = 4 * NUM_DIGITS;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  step;
  logic                  s1_level_unused;
  logic                  dir_s1;
  logic                  dir_s2;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      next_count;
  logic                  all_wrap;
  logic                  wrap_q;
  logic [DIV_W-1:0]      div_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_next;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            sel_digit;
  logic [7:0]            led_q;
  logic [NUM_DIGITS-1:0] digit_en_q;

  // Only the press edge steps the counter; the debounced level is not used.
  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_s1_debounce (
    .clock(clock),
    .rst  (rst),
    .din  (bus.s1),
    .dout (s1_level_unused),
    .rise (step)
  );

  // Direction is a slow level, so a plain synchroniser is enough.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      dir_s1 <= bus.dir;
      dir_s2 <= dir_s1;
    end
  end

  // Ripple carry/borrow through the digits: a digit moves only while every
  // lower digit has wrapped. A carry out of the top digit is a full wrap.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    next_count = count_q;
    carry      = 1'b1;
    digit      = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit = count_q[4*k +: 4];
      if (carry) begin
        if (!dir_s2) begin
          if (digit == 4'd9) begin
            next_count[4*k +: 4] = 4'd0;
          end else begin
            next_count[4*k +: 4] = digit + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            next_count[4*k +: 4] = 4'd9;
          end else begin
            next_count[4*k +: 4] = digit - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
    all_wrap = carry;
  end

  // Clear takes priority over a coincident step and suppresses wrap.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.clr) begin
        count_q <= '0;
      end else if (step) begin
        count_q <= next_count;
        wrap_q  <= all_wrap;
      end
    end
  end

  // The index moves on the divider's terminal count, giving each digit a
  // dwell of exactly SCAN_DIV cycles.
  always_comb begin
    idx_next = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_next = '0;
      end else begin
        idx_next = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      idx_q <= idx_next;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Walk down from the top digit: a digit is a leading zero when it and
  // everything above it is zero. Digit 0 never blanks.
  always_comb begin
    logic higher_zero;
    blank       = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      higher_zero = higher_zero & (count_q[4*k +: 4] == 4'd0);
      blank[k]    = LEAD_BLANK & higher_zero;
    end
  end

  always_comb begin
    sel_digit = count_q[{idx_next, 2'b00} +: 4];
  end

  // Segments and enables are registered from the same next index so they
  // switch together and the shared bus never shows a wrong digit.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      led_q      <= SEG_0;
      digit_en_q <= NUM_DIGITS'(1);
    end else begin
      digit_en_q <= NUM_DIGITS'(1) << idx_next;
      led_q      <= blank[idx_next] ? SEG_BLANK : bcd_to_seg(sel_digit);
    end
  end

  assign bus.led      = led_q;
  assign bus.digit_en = digit_en_q;
  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_counter
// Self-checking bench for bcd_scan_counter with NUM_DIGITS=2,
// DEBOUNCE_CYCLES=4, SCAN_DIV=8, LEAD_BLANK=1. The reference holds the count
// as a plain integer 0..99 and derives BCD, wrap, scan position and segment
// bytes arithmetically.
// ---------------------------------------------------------------------------
module tb_bcd_scan_counter;

  localparam int N = 2;
  localparam int D = 4;
  localparam int S = 8;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  int checks    = 0;
  int errors    = 0;
  int model_val = 0;
  int shown_val = 0;
  int scan_k    = 0;
  int mon_idx   = 0;

  always #5 clock = ~clock;

  bcd_scan_counter_if #(.NUM_DIGITS(N)) bus ();

  bcd_scan_counter #(
    .NUM_DIGITS     (N),
    .DEBOUNCE_CYCLES(D),
    .SCAN_DIV       (S),
    .LEAD_BLANK     (1'b1)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] segOf(input int d);
    case (d)
      0: return 8'hFC;
      1: return 8'h60;
      2: return 8'hDA;
      3: return 8'hF2;
      4: return 8'h66;
      5: return 8'hB6;
      6: return 8'hBE;
      7: return 8'hE0;
      8: return 8'hFE;
      9: return 8'hE6;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] expLed(input int v, input int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && v < p) return 8'h00;
    return segOf((v / p) % 10);
  endfunction

  function automatic logic [31:0] toBcd(input int v);
    return 32'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Scan monitor: the digit shown after an edge is edge_count/S mod N, and
  // the segment byte reflects the count value held just before that edge.
  always @(posedge clock) begin
    if (!rst) scan_k = 0;
    else      scan_k++;
    shown_val = model_val;
    #1;
    mon_idx = (scan_k / S) % N;
    checkOutput("scan_digit_en", 32'(bus.digit_en), 32'(1 << mon_idx));
    checkOutput("scan_led", 32'(bus.led), 32'(expLed(shown_val, mon_idx)));
  end

  task automatic applyStimulus(input logic s1v, input logic dirv,
                               input logic clrv, input int cycles);
    bus.s1  = s1v;
    bus.dir = dirv;
    bus.clr = clrv;
    repeat (cycles) @(negedge clock);
  endtask

  // Called at the negedge where s1 was just raised (cleanly). The count must
  // hold through 2+D+1 edges and move on the next one.
  task automatic waitStep(input int dirv, input bit do_clr);
    int expv;
    bit expw;
    repeat (D + 3) @(negedge clock);
    checkOutput("pre_step_count", 32'(bus.count), toBcd(model_val));
    if (do_clr) bus.clr = 1'b1;
    @(negedge clock);
    bus.clr = 1'b0;
    if (do_clr) begin
      expv = 0;
      expw = 1'b0;
    end else if (dirv == 0) begin
      expw = (model_val == 99);
      expv = (model_val + 1) % 100;
    end else begin
      expw = (model_val == 0);
      expv = (model_val + 99) % 100;
    end
    model_val = expv;
    checkOutput("step_count", 32'(bus.count), toBcd(expv));
    checkOutput("step_wrap", 32'(bus.wrap), 32'(expw));
    @(negedge clock);
    checkOutput("wrap_pulse_end", 32'(bus.wrap), 32'd0);
  endtask

  task automatic pressExact(input int dirv, input bit do_clr, input bit glitch);
    applyStimulus(1'b0, 1'(dirv), 1'b0, 3);
    if (glitch) begin
      applyStimulus(1'b1, 1'(dirv), 1'b0, $urandom_range(1, D - 1));
      applyStimulus(1'b0, 1'(dirv), 1'b0, $urandom_range(2, 4));
    end
    bus.s1 = 1'b1;
    waitStep(dirv, do_clr);
    applyStimulus(1'b1, 1'(dirv), 1'b0, 2);
    applyStimulus(1'b0, 1'(dirv), 1'b0, D + 4);
  endtask

  task automatic doClear();
    bus.clr = 1'b1;
    @(negedge clock);
    bus.clr   = 1'b0;
    model_val = 0;
    checkOutput("clr_count", 32'(bus.count), 32'd0);
  endtask

  task automatic waitDigit(input logic [N-1:0] sel);
    for (int i = 0; i < N * S + 2 && bus.digit_en !== sel; i++) @(negedge clock);
    checkOutput("wait_digit_en", 32'(bus.digit_en), 32'(sel));
  endtask

  initial begin
    bus.s1  = 1'b0;
    bus.dir = 1'b0;
    bus.clr = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_count", 32'(bus.count), 32'd0);
    checkOutput("reset_wrap", 32'(bus.wrap), 32'd0);
    checkOutput("reset_digit_en", 32'(bus.digit_en), 32'd1);
    checkOutput("reset_led", 32'(bus.led), 32'hFC);
    rst = 1'b1;
    repeat (32) @(negedge clock);
    checkOutput("idle_count", 32'(bus.count), 32'd0);

    $display("[TB] bouncing press");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
    end
    bus.s1 = 1'b1;
    waitStep(0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, D + 4);
    checkOutput("bounce_one_step", 32'(bus.count), 32'h01);

    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("short_pulse_ignored", 32'(bus.count), 32'h01);

    $display("[TB] count up to 99 and wrap");
    doClear();
    for (int i = 0; i < 99; i++) pressExact(0, 1'b0, 1'b0);
    checkOutput("count_99", 32'(bus.count), 32'h99);
    waitDigit(2'b10);
    checkOutput("led_digit1_99", 32'(bus.led), 32'hE6);
    pressExact(0, 1'b0, 1'b0);
    checkOutput("count_wrap_00", 32'(bus.count), 32'h00);

    $display("[TB] down stepping and blanking");
    for (int i = 0; i < 10; i++) pressExact(0, 1'b0, 1'b1);
    checkOutput("count_10", 32'(bus.count), 32'h10);
    pressExact(1, 1'b0, 1'b0);
    waitDigit(2'b01);
    waitDigit(2'b10);
    checkOutput("blank_digit1_09", 32'(bus.led), 32'h00);
    pressExact(1, 1'b0, 1'b0);
    checkOutput("count_08", 32'(bus.count), 32'h08);
    doClear();
    pressExact(1, 1'b0, 1'b0);
    checkOutput("count_down_wrap_99", 32'(bus.count), 32'h99);

    $display("[TB] randomized presses");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) doClear();
      pressExact(int'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] clear versus step");
    doClear();
    for (int i = 0; i < 42; i++) pressExact(0, 1'b0, 1'($urandom_range(0, 1)));
    checkOutput("count_42", 32'(bus.count), 32'h42);
    pressExact(0, 1'b1, 1'b0);

    $display("[TB] reset mid-debounce and mid-scan");
    bus.dir = 1'b0;
    waitDigit(2'b01);
    waitDigit(2'b10);
    bus.s1 = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("pre_reset_digit_en", 32'(bus.digit_en), 32'h2);
    rst       = 1'b0;
    model_val = 0;
    #1;
    checkOutput("midrst_count", 32'(bus.count), 32'd0);
    checkOutput("midrst_wrap", 32'(bus.wrap), 32'd0);
    checkOutput("midrst_digit_en", 32'(bus.digit_en), 32'd1);
    checkOutput("midrst_led", 32'(bus.led), 32'hFC);
    repeat (3) @(negedge clock);
    rst = 1'b1;
    waitStep(0, 1'b0);
    checkOutput("post_reset_press", 32'(bus.count), 32'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, D + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
